// File: rtl/psmac_pkg.sv
// Shared definitions for the fragment multiplier datapath: MFU sign-mode codes
// and the fragment issuer state encoding.
package psmac_pkg;

    localparam logic [1:0] UU = 2'b00;
    localparam logic [1:0] US = 2'b01;
    localparam logic [1:0] SU = 2'b10;
    localparam logic [1:0] SS = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/psmac_frag_issue.sv
// Splits one operand pair into K*K 2-bit fragment pairs (op_b index inner),
// tagging each with its MFU sign mode and product shift for the accumulator.
module psmac_frag_issue
    import psmac_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = $clog2(2*N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  op_a,
    input  logic [N-1:0]  op_b,
    input  logic          a_signed,
    input  logic          b_signed,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [1:0]    frag_a,
    output logic [1:0]    frag_b,
    output logic [1:0]    frag_sel,
    output logic [SW-1:0] frag_shift,
    output logic          frag_last,
    output logic          frag_valid,
    input  logic          frag_ready
);

    localparam int K  = N / 2;
    localparam int IW = $clog2(K);
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    state_t         state, state_nxt;
    logic [N-1:0]   a_q, b_q;
    logic           as_q, bs_q;
    logic [IW-1:0]  i_q, j_q;

    logic           accept, xfer, advance;
    logic [N-1:0]   src_a, src_b, sh_a, sh_b;
    logic           src_as, src_bs;
    logic [IW-1:0]  ld_i, ld_j;
    logic [SW-1:0]  idx_sum;

    assign accept  = in_valid & in_ready;
    assign xfer    = frag_valid & frag_ready;
    assign advance = accept | (xfer & ~frag_last);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)               state_nxt = ISSUE;
            ISSUE:   if (frag_ready && frag_last) state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state == IDLE);
    end

    // The first fragment comes straight from the inputs (operands not yet
    // captured); later fragments walk the captured copy.
    always_comb begin
        src_a  = a_q;
        src_b  = b_q;
        src_as = as_q;
        src_bs = bs_q;
        ld_i   = i_q;
        ld_j   = j_q;
        if (state == IDLE) begin
            src_a  = op_a;
            src_b  = op_b;
            src_as = a_signed;
            src_bs = b_signed;
            ld_i   = '0;
            ld_j   = '0;
        end else if (j_q == LAST_IDX) begin
            ld_i = i_q + IW'(1);
            ld_j = '0;
        end else begin
            ld_j = j_q + IW'(1);
        end
    end

    assign sh_a    = src_a >> {ld_i, 1'b0};
    assign sh_b    = src_b >> {ld_j, 1'b0};
    assign idx_sum = SW'(ld_i) + SW'(ld_j);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the operand copy is reset too, since it is cheap and keeps post-reset state fully defined.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            as_q       <= 1'b0;
            bs_q       <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            frag_a     <= '0;
            frag_b     <= '0;
            frag_sel   <= '0;
            frag_shift <= '0;
            frag_last  <= 1'b0;
            frag_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= op_a;
                b_q  <= op_b;
                as_q <= a_signed;
                bs_q <= b_signed;
            end
            if (advance) begin
                i_q        <= ld_i;
                j_q        <= ld_j;
                frag_a     <= sh_a[1:0];
                frag_b     <= sh_b[1:0];
                frag_sel   <= {src_as & (ld_i == LAST_IDX), src_bs & (ld_j == LAST_IDX)};
                frag_shift <= {idx_sum[SW-2:0], 1'b0};
                frag_last  <= (ld_i == LAST_IDX) && (ld_j == LAST_IDX);
                frag_valid <= 1'b1;
            end else if (xfer) begin
                frag_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psmac_frag_issue.sv
// Bench for psmac_frag_issue: fragment streams are reconstructed into a product
// and compared with a plain-arithmetic reference, alongside directed scenarios.
module tb_psmac_frag_issue;

    localparam int N  = 8;
    localparam int SW = $clog2(2*N);
    localparam int K  = N / 2;
    localparam longint MASK = (64'sd1 <<< (2*N)) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  op_a = '0, op_b = '0;
    logic          a_signed = 1'b0, b_signed = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    frag_a, frag_b, frag_sel;
    logic [SW-1:0] frag_shift;
    logic          frag_last, frag_valid;
    logic          frag_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [1:0]    q_a[$], q_b[$], q_sel[$];
    logic [SW-1:0] q_sh[$];
    logic          q_last[$];
    int            q_cyc[$];
    logic [7+SW:0] q_hold[$];

    psmac_frag_issue #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_a(op_a), .op_b(op_b), .a_signed(a_signed), .b_signed(b_signed),
        .in_valid(in_valid), .in_ready(in_ready),
        .frag_a(frag_a), .frag_b(frag_b), .frag_sel(frag_sel),
        .frag_shift(frag_shift), .frag_last(frag_last),
        .frag_valid(frag_valid), .frag_ready(frag_ready)
    );

    always #5 clk = ~clk;

    // Exact product under the given signedness, truncated to 2N bits.
    function automatic longint ref_prod(input logic [N-1:0] a, b, input logic as_, bs_);
        longint va, vb;
        va = longint'(a);
        vb = longint'(b);
        if (as_ && a[N-1]) va = va - (64'sd1 <<< N);
        if (bs_ && b[N-1]) vb = vb - (64'sd1 <<< N);
        return (va * vb) & MASK;
    endfunction

    // What an MFU + shifting accumulator would rebuild from the captured fragments.
    function automatic longint recon();
        longint sum, va, vb;
        sum = 0;
        for (int k = 0; k < q_a.size(); k++) begin
            va = longint'(q_a[k]);
            vb = longint'(q_b[k]);
            if (q_sel[k][1] && q_a[k][1]) va = va - 4;
            if (q_sel[k][0] && q_b[k][1]) vb = vb - 4;
            sum = sum + ((va * vb) <<< q_sh[k]);
        end
        return sum & MASK;
    endfunction

    // Expected fragment stream, in (i outer, j inner) order.
    function automatic bit fields_ok(input logic [N-1:0] a, b, input logic as_, bs_);
        logic [N-1:0] ta, tb;
        int i, j;
        if (q_a.size() != K*K) return 1'b0;
        for (int n = 0; n < K*K; n++) begin
            i  = n / K;
            j  = n % K;
            ta = a >> (2*i);
            tb = b >> (2*j);
            if (q_a[n] !== ta[1:0]) return 1'b0;
            if (q_b[n] !== tb[1:0]) return 1'b0;
            if (q_sel[n] !== {as_ && (i == K-1), bs_ && (j == K-1)}) return 1'b0;
            if (int'(q_sh[n]) != 2*(i+j)) return 1'b0;
            if (q_last[n] !== (n == K*K-1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int count_last();
        int c = 0;
        foreach (q_last[k]) if (q_last[k]) c++;
        return c;
    endfunction

    // Presents one operand pair (DUT must be idle) and collects every
    // transferred fragment; optional stall, in_valid noise and reset abort.
    task automatic run_op(input logic [N-1:0] a, b, input logic as_, bs_,
                          input bit rnd_ready, input int stall_at, input int stall_len,
                          input bit pulse_iv, input int abort_at, output bit timeout);
        int cyc, stalled;
        bit done;
        q_a.delete(); q_b.delete(); q_sel.delete(); q_sh.delete();
        q_last.delete(); q_cyc.delete(); q_hold.delete();
        op_a = a; op_b = b; a_signed = as_; b_signed = bs_;
        in_valid = 1'b1; frag_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1; stalled = 0; done = 1'b0; timeout = 1'b0;
        while (!done) begin
            if (cyc > 400) begin
                timeout = 1'b1;
                break;
            end
            op_a = N'($urandom);
            op_b = N'($urandom);
            a_signed = 1'($urandom_range(0, 1));
            b_signed = 1'($urandom_range(0, 1));
            in_valid = pulse_iv ? 1'($urandom_range(0, 1)) : 1'b0;
            if (q_a.size() == abort_at && frag_valid) begin
                rst_n = 1'b0;
                frag_ready = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                break;
            end
            frag_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (q_a.size() == stall_at && stalled < stall_len) begin
                frag_ready = 1'b0;
                stalled++;
                q_hold.push_back({frag_valid, frag_a, frag_b, frag_sel, frag_shift, frag_last});
            end
            if (frag_valid && frag_ready) begin
                q_a.push_back(frag_a);
                q_b.push_back(frag_b);
                q_sel.push_back(frag_sel);
                q_sh.push_back(frag_shift);
                q_last.push_back(frag_last);
                q_cyc.push_back(cyc);
                if (frag_last) done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        frag_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        total++;
        if ({frag_valid, frag_a, frag_b, frag_sel, frag_shift, frag_last} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b a=%b b=%b sel=%b sh=%0d last=%b, want all 0",
                     frag_valid, frag_a, frag_b, frag_sel, frag_shift, frag_last);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || frag_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_hold: got in_ready=%b valid=%b want 1/0", in_ready, frag_valid);
        end
    endtask

    task automatic test_unsigned();
        bit to;
        run_op(8'hB4, 8'h03, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, -1, to);
        total++;
        if (to || q_a.size() != 16) begin
            bad++;
            $display("FAIL uns_count: got %0d frags (timeout=%b) want 16", q_a.size(), to);
        end else begin
            total++;
            if ({q_a[0], q_b[0], q_sel[0], q_sh[0]} !== {2'b00, 2'b11, 2'b00, SW'(0)}) begin
                bad++;
                $display("FAIL uns_first: got a=%b b=%b sel=%b sh=%0d want 00 11 00 0",
                         q_a[0], q_b[0], q_sel[0], q_sh[0]);
            end
            total++;
            if ({q_a[3], q_b[3], q_sel[3], q_sh[3]} !== {2'b00, 2'b00, 2'b00, SW'(6)}) begin
                bad++;
                $display("FAIL uns_fourth: got a=%b b=%b sel=%b sh=%0d want 00 00 00 6",
                         q_a[3], q_b[3], q_sel[3], q_sh[3]);
            end
            total++;
            if ({q_a[15], q_b[15], q_sel[15], q_sh[15], q_last[15]} !== {2'b10, 2'b00, 2'b00, SW'(12), 1'b1}) begin
                bad++;
                $display("FAIL uns_last: got a=%b b=%b sel=%b sh=%0d last=%b want 10 00 00 12 1",
                         q_a[15], q_b[15], q_sel[15], q_sh[15], q_last[15]);
            end
            total++;
            if (q_cyc[0] != 1 || q_cyc[15] != 16) begin
                bad++;
                $display("FAIL uns_timing: got first cycle %0d last cycle %0d want 1 and 16", q_cyc[0], q_cyc[15]);
            end
            total++;
            if (!fields_ok(8'hB4, 8'h03, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL uns_fields: stream differs from expected fragment order");
            end
            total++;
            if (recon() != ref_prod(8'hB4, 8'h03, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL uns_recon: got %h want %h", recon(), ref_prod(8'hB4, 8'h03, 1'b0, 1'b0));
            end
        end
        total++;
        if (in_ready !== 1'b1 || frag_valid !== 1'b0) begin
            bad++;
            $display("FAIL uns_return_idle: got in_ready=%b valid=%b want 1/0", in_ready, frag_valid);
        end
    endtask

    task automatic test_signed();
        bit to;
        run_op(8'hB4, 8'h03, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, -1, to);
        total++;
        if (to || !fields_ok(8'hB4, 8'h03, 1'b1, 1'b1)) begin
            bad++;
            $display("FAIL ss_sel_pattern: stream or sel codes wrong (count=%0d timeout=%b)", q_a.size(), to);
        end
        total++;
        if (recon() != 64'hFF1C) begin
            bad++;
            $display("FAIL ss_recon: got %h want ff1c", recon());
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [7+SW:0] want;
        want = {1'b1, 2'b01, 2'b11, 2'b00, SW'(2), 1'b0};
        run_op(8'hB4, 8'h03, 1'b0, 1'b0, 1'b0, 4, 3, 1'b1, -1, to);
        total++;
        if (q_hold.size() != 3) begin
            bad++;
            $display("FAIL bp_stall_len: got %0d stall samples want 3", q_hold.size());
        end
        foreach (q_hold[k]) begin
            total++;
            if (q_hold[k] !== want) begin
                bad++;
                $display("FAIL bp_hold: stall %0d got %h want %h", k, q_hold[k], want);
            end
        end
        total++;
        if (to || !fields_ok(8'hB4, 8'h03, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL bp_stream: got %0d frags (timeout=%b), want 16 in order", q_a.size(), to);
        end
        total++;
        if (in_ready !== 1'b1 || frag_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_accept: got in_ready=%b valid=%b want 1/0", in_ready, frag_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        run_op(8'hB4, 8'h03, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 6, to);
        total++;
        if (frag_valid !== 1'b0 || in_ready !== 1'b1 || q_a.size() != 6) begin
            bad++;
            $display("FAIL mid_reset_abort: got valid=%b in_ready=%b frags=%0d want 0/1/6",
                     frag_valid, in_ready, q_a.size());
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, -1, to);
        total++;
        if (to || q_a.size() != 16 || {q_a[0], q_b[0], q_sh[0]} !== {2'b11, 2'b11, SW'(0)}) begin
            bad++;
            $display("FAIL mid_restart: got %0d frags (timeout=%b), first fragment not (0,0)", q_a.size(), to);
        end
        total++;
        if (recon() != 1) begin
            bad++;
            $display("FAIL mid_recon: got %h want 1", recon());
        end
    endtask

    task automatic test_random();
        bit to;
        logic [N-1:0] a, b;
        logic as_, bs_;
        for (int n = 0; n < 1000; n++) begin
            a = N'($urandom);
            b = N'($urandom);
            as_ = 1'($urandom_range(0, 1));
            bs_ = 1'($urandom_range(0, 1));
            run_op(a, b, as_, bs_, 1'b1, -1, 0, 1'($urandom_range(0, 1)), -1, to);
            total++;
            if (to || recon() != ref_prod(a, b, as_, bs_)) begin
                bad++;
                $display("FAIL rnd_recon: op %0d a=%h b=%h s=%b%b got %h want %h (timeout=%b)",
                         n, a, b, as_, bs_, recon(), ref_prod(a, b, as_, bs_), to);
            end
            total++;
            if (count_last() != 1 || !fields_ok(a, b, as_, bs_)) begin
                bad++;
                $display("FAIL rnd_stream: op %0d got %0d frags with %0d last flags want 16 and 1",
                         n, q_a.size(), count_last());
            end
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
